// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the integer register file: round-robin grant of N_SRC
// result sources onto the single write port, plus a per-register pending-write
// scoreboard for issue hazard checks. Define GPR_WB_REG_EN for a registered output stage.
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5,
  parameter int N_SRC      = 3,
  parameter int CNT_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic [RF_SIZE-1:0]            issue_rd,
  output logic                          issue_ready,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*RF_SIZE-1:0]      src_rd,
  input  logic [N_SRC*DATA_WIDTH-1:0]   src_data,
  output logic [N_SRC-1:0]              src_ready,
  output logic [RF_SIZE-1:0]            wb_rd,
  output logic                          wb_we,
  output logic [DATA_WIDTH-1:0]         wb_data,
  input  logic [RF_SIZE-1:0]            rs1,
  input  logic [RF_SIZE-1:0]            rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          idle
);

  localparam int NREG  = 2**RF_SIZE;
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W:0]        cand_s;
  logic                  hit_s;
  logic                  grant_vld_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [N_SRC-1:0]      grant_oh_s;
  logic [RF_SIZE-1:0]    sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  wb_we_s;
  logic [RF_SIZE-1:0]    wb_rd_s;
  logic [DATA_WIDTH-1:0] wb_data_s;
  logic                  stage_pend_s;
  logic                  issue_ready_s;
  logic                  issue_acc_s;
  logic [NREG-1:0]       inc_s, dec_s;
  logic                  any_cnt_s;
  logic [CNT_W-1:0]      cnt_q [NREG];
  logic [CNT_W-1:0]      cnt_d [NREG];

  // Round-robin search from ptr_q; the lowest offset with a valid request wins.
  // Reset gates the grant so nothing is acknowledged while rst_n is low.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand_s      = {1'b0, ptr_q} + (PTR_W+1)'(k);
      cand_s      = (cand_s >= (PTR_W+1)'(N_SRC)) ? cand_s - (PTR_W+1)'(N_SRC) : cand_s;
      hit_s       = src_valid[cand_s[PTR_W-1:0]] & rst_n;
      grant_vld_s = grant_vld_s | hit_s;
      grant_idx_s = hit_s ? cand_s[PTR_W-1:0] : grant_idx_s;
    end
    grant_oh_s = grant_vld_s ? (N_SRC'(1'b1) << grant_idx_s) : '0;
    if (grant_vld_s) begin
      ptr_d = (grant_idx_s == PTR_W'(N_SRC - 1)) ? '0 : grant_idx_s + PTR_W'(1'b1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // AND-OR mux of the granted source's destination and data.
  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_rd_s   = sel_rd_s   | ({RF_SIZE{grant_oh_s[i]}}    & src_rd[i*RF_SIZE +: RF_SIZE]);
      sel_data_s = sel_data_s | ({DATA_WIDTH{grant_oh_s[i]}} & src_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef GPR_WB_REG_EN
  logic                  stage_we_q;
  logic [RF_SIZE-1:0]    stage_rd_q;
  logic [DATA_WIDTH-1:0] stage_data_q;

  // Output stage captures the grant and drains unconditionally on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_we_q   <= 1'b0;
      stage_rd_q   <= '0;
      stage_data_q <= '0;
    end else begin
      stage_we_q   <= grant_vld_s & (sel_rd_s != '0);
      stage_rd_q   <= sel_rd_s;
      stage_data_q <= sel_data_s;
    end
  end

  assign wb_we_s      = stage_we_q;
  assign wb_rd_s      = stage_rd_q;
  assign wb_data_s    = stage_data_q;
  assign stage_pend_s = stage_we_q;
`else
  assign wb_we_s      = grant_vld_s & (sel_rd_s != '0);
  assign wb_rd_s      = sel_rd_s;
  assign wb_data_s    = sel_data_s;
  assign stage_pend_s = 1'b0;
`endif

  // A full counter still accepts when the same register retires this cycle.
  assign issue_ready_s = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX) ||
                         (wb_we_s && (wb_rd_s == issue_rd));
  assign issue_acc_s   = issue_valid & issue_ready_s & (issue_rd != '0);
  assign inc_s = issue_acc_s ? (NREG'(1'b1) << issue_rd) : '0;
  assign dec_s = wb_we_s     ? (NREG'(1'b1) << wb_rd_s)  : '0;

  // Counter next state; a retire on an empty counter is ignored, x0 stays zero.
  always_comb begin
    any_cnt_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      any_cnt_s = any_cnt_s | (cnt_q[r] != '0);
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_s[r] && !dec_s[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1'b1);
      end else if (dec_s[r] && !inc_s[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1'b1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Pending-write scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign issue_ready = issue_ready_s;
  assign src_ready   = grant_oh_s;
  assign wb_we       = wb_we_s;
  assign wb_rd       = wb_rd_s;
  assign wb_data     = wb_data_s;
  assign rs1_busy    = (cnt_q[rs1] != '0);
  assign rs2_busy    = (cnt_q[rs2] != '0);
  assign idle        = ~any_cnt_s & ~stage_pend_s;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter; expectations target the default zero-latency
// build, with the latency vector also covering GPR_WB_REG_EN.
module tb_gpr_wb_arbiter;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int NS = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               issue_valid;
  logic [RW-1:0]      issue_rd;
  logic               issue_ready;
  logic [NS-1:0]      src_valid;
  logic [NS*RW-1:0]   src_rd;
  logic [NS*DW-1:0]   src_data;
  logic [NS-1:0]      src_ready;
  logic [RW-1:0]      wb_rd;
  logic               wb_we;
  logic [DW-1:0]      wb_data;
  logic [RW-1:0]      rs1, rs2;
  logic               rs1_busy, rs2_busy, idle;

  int n_cmp = 0;
  int n_err = 0;

  gpr_wb_arbiter #(.DATA_WIDTH(DW), .RF_SIZE(RW), .N_SRC(NS), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data), .src_ready(src_ready),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] d);
    src_rd[i*RW +: RW]   = rd;
    src_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    src_valid = '0; src_rd = '0; src_data = '0; rs1 = '0; rs2 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_src_ready", src_ready, 0);

    // 1: reset asserted mid-traffic
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    set_src(0, 5'd9, 64'h100); set_src(1, 5'd10, 64'h101); set_src(2, 5'd11, 64'h102);
    src_valid = 3'b111;
    #1;
    chk("pre_idle", idle, 0);
    chk("pre_grant", src_ready, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("inrst_we", wb_we, 0);
    chk("inrst_ready", src_ready, 0);
    chk("inrst_idle", idle, 1);
    tick();
    rst_n = 1'b1;
    #1;

    // 2: round robin, first grant after release to source 0
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", src_ready, 3'b001 << (k % 3));
      chk("rr_rd", wb_rd, 5'd9 + 5'(k % 3));
      chk("rr_data", wb_data, 64'h100 + 64'(k % 3));
      chk("rr_we", wb_we, 1);
      tick();
    end
    src_valid = '0;

    // 3: scoreboard counts two writes to x5
    issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    #1;
    chk("sb_ready1", issue_ready, 1);
    chk("sb_busy0", rs1_busy, 0);
    tick();
    chk("sb_ready2", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    set_src(0, 5'd5, 64'h55);
    src_valid = 3'b001;
    #1;
    chk("sb_busy2", rs1_busy, 1);
    chk("sb_we1", wb_we, 1);
    chk("sb_rd1", wb_rd, 5);
    tick();
    chk("sb_busy1", rs1_busy, 1);
    chk("sb_busy1_rs2", rs2_busy, 1);
    tick();
    src_valid = '0;
    #1;
    chk("sb_clear", rs1_busy, 0);
    chk("sb_idle", idle, 1);

    // 4: saturation on x7 (pointer now at source 1)
    issue_valid = 1'b1; issue_rd = 5'd7;
    repeat (3) tick();
    #1;
    chk("sat_full", issue_ready, 0);
    set_src(1, 5'd7, 64'h77);
    src_valid = 3'b010;
    #1;
    chk("sat_retire", issue_ready, 1);
    chk("sat_grant", src_ready, 3'b010);
    tick();
    issue_valid = 1'b0; src_valid = '0;
    #1;
    chk("sat_still_full", issue_ready, 0);
    src_valid = 3'b010;
    repeat (3) tick();
    src_valid = '0; rs1 = 5'd7;
    #1;
    chk("sat_drained", rs1_busy, 0);
    chk("sat_idle", idle, 1);

    // 5: write to x0 (pointer now at source 2)
    set_src(2, 5'd0, 64'hDEAD);
    src_valid = 3'b100;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    #1;
    chk("x0_grant", src_ready, 3'b100);
    chk("x0_we", wb_we, 0);
    chk("x0_issue", issue_ready, 1);
    chk("x0_busy", rs1_busy, 0);
    tick();
    issue_valid = 1'b0; src_valid = '0;
    #1;
    chk("x0_idle", idle, 1);

    // 6: single source latency (pointer now at source 0, request on source 1)
    set_src(1, 5'd12, 64'hCAFE);
    src_valid = 3'b010;
    #1;
    chk("lat_grant", src_ready, 3'b010);
`ifdef GPR_WB_REG_EN
    chk("lat_we_same", wb_we, 0);
    tick();
    src_valid = '0;
    #1;
    chk("lat_we_next", wb_we, 1);
    chk("lat_data", wb_data, 64'hCAFE);
`else
    chk("lat_we_same", wb_we, 1);
    chk("lat_data", wb_data, 64'hCAFE);
    chk("lat_rd", wb_rd, 12);
    tick();
    src_valid = '0;
    #1;
    chk("lat_we_off", wb_we, 0);
`endif
    tick();
    chk("end_idle", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
